// File: rtl/game_pkg.sv
// Shared types and constants for the game-flow controller and the colour mapper.
// Display codes are what the colour mapper decodes; both fade states share one code.
package game_pkg;

  typedef enum logic [2:0] {
    ST_INIT      = 3'd0,
    ST_SELECT    = 3'd1,
    ST_MAP       = 3'd2,
    ST_BATTLE    = 3'd3,
    ST_TRANS_IN  = 3'd4,
    ST_TRANS_OUT = 3'd5,
    ST_PAUSE     = 3'd6,
    ST_GAME_OVER = 3'd7
  } game_state_t;

  localparam logic [2:0] DISP_INIT      = 3'd0;
  localparam logic [2:0] DISP_SELECT    = 3'd1;
  localparam logic [2:0] DISP_MAP       = 3'd2;
  localparam logic [2:0] DISP_BATTLE    = 3'd3;
  localparam logic [2:0] DISP_TRANS     = 3'd4;
  localparam logic [2:0] DISP_PAUSE     = 3'd5;
  localparam logic [2:0] DISP_GAME_OVER = 3'd6;

  localparam logic [7:0] KEY_START_DEF = 8'h28;
  localparam logic [7:0] KEY_PAUSE_DEF = 8'h29;
  localparam logic [7:0] KEY_FORCE_DEF = 8'h05;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/game_flow_ctrl_if.sv
// Bundle of frame/key/battle-engine inputs and screen/datapath control outputs.
// Handshake: battle_done is a one-cycle pulse qualified by battle_lost; there is no back-pressure.
interface game_flow_ctrl_if #(
  parameter int NUM_STARTERS = 3,
  parameter int TRANS_FRAMES = 16
);
  import game_pkg::*;

  localparam int SW = sel_width(NUM_STARTERS);
  localparam int TW = $clog2(TRANS_FRAMES + 1);

  logic          frame_tick;
  logic [7:0]    keycode;
  logic          encounter;
  logic          battle_done;
  logic          battle_lost;
  logic [2:0]    display_control;
  logic [SW-1:0] starter_sel;
  logic          starter_valid;
  logic          fight_on;
  logic          during_battle;
  logic          wild_poke_reg;
  logic          init_reg_select;
  logic [TW-1:0] trans_count;
  game_state_t   state;

  modport master (
    output frame_tick, keycode, encounter, battle_done, battle_lost,
    input  display_control, starter_sel, starter_valid, fight_on, during_battle,
           wild_poke_reg, init_reg_select, trans_count, state
  );

  modport slave (
    input  frame_tick, keycode, encounter, battle_done, battle_lost,
    output display_control, starter_sel, starter_valid, fight_on, during_battle,
           wild_poke_reg, init_reg_select, trans_count, state
  );

endinterface

// File: rtl/key_edge_det.sv
// Frame-rate key edge detector: press fires once when a new non-zero keycode is seen at a tick.
module key_edge_det (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic [7:0] keycode,
  output logic       press,
  output logic [7:0] key_prev
);

  always_ff @(posedge clk) begin
    if (!rst_n)          key_prev <= 8'h00;
    else if (frame_tick) key_prev <= keycode;
  end

  assign press = frame_tick && (keycode != 8'h00) && (keycode != key_prev);

endmodule

// File: rtl/game_flow_ctrl.sv
// Game-flow controller: sequences title, starter select, map, fades, battle, pause and game over,
// and decodes screen mode and datapath load controls from the current state.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int                        NUM_STARTERS = 3,
  parameter logic [NUM_STARTERS*8-1:0] STARTER_KEYS = {8'h07, 8'h16, 8'h04},
  parameter logic [7:0]                KEY_START    = KEY_START_DEF,
  parameter logic [7:0]                KEY_PAUSE    = KEY_PAUSE_DEF,
  parameter logic [7:0]                KEY_FORCE    = KEY_FORCE_DEF,
  parameter bit                        DEBUG_KEYS   = 1'b1,
  parameter int                        TRANS_FRAMES = 16
) (
  input logic             Clk,
  input logic             Reset_n,
  game_flow_ctrl_if.slave bus
);

  localparam int SW = sel_width(NUM_STARTERS);
  localparam int TW = $clog2(TRANS_FRAMES + 1);
  localparam logic [TW-1:0] TC_LOAD = TW'(TRANS_FRAMES - 1);

  game_state_t   state_q, state_d;
  logic [TW-1:0] tc_q, tc_d;
  logic [SW-1:0] sel_q, sel_d, sel_idx;
  logic          valid_q, valid_d, sel_hit;
  logic          done_q, done_d, lost_q, lost_d, done_now, lost_now;
  logic          key_press, press_start, press_pause, press_force;
  logic [7:0]    key_prev;

  key_edge_det u_key_edge (
    .clk       (Clk),
    .rst_n     (Reset_n),
    .frame_tick(bus.frame_tick),
    .keycode   (bus.keycode),
    .press     (key_press),
    .key_prev  (key_prev)
  );

  assign press_start = key_press && (bus.keycode == KEY_START);
  assign press_pause = key_press && (bus.keycode == KEY_PAUSE);
  assign press_force = key_press && (bus.keycode == KEY_FORCE);

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= ST_INIT;
      tc_q    <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tc_q    <= tc_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      lost_q  <= lost_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    tc_d     = tc_q;
    sel_d    = sel_q;
    valid_d  = valid_q;
    sel_hit  = 1'b0;
    sel_idx  = '0;
    // A done pulse between ticks is remembered; one coinciding with a tick acts immediately.
    done_now = done_q | bus.battle_done;
    lost_now = lost_q | (bus.battle_done & bus.battle_lost);

    // Descending scan so the lowest index wins when keycodes are duplicated.
    for (int i = NUM_STARTERS - 1; i >= 0; i--) begin
      if (key_press && (bus.keycode == STARTER_KEYS[i*8 +: 8])) begin
        sel_hit = 1'b1;
        sel_idx = SW'(i);
      end
    end

    case (state_q)
      ST_INIT:   if (press_start) state_d = ST_SELECT;
      ST_SELECT: if (sel_hit) begin
        sel_d   = sel_idx;
        valid_d = 1'b1;
        state_d = ST_MAP;
      end
      ST_MAP: begin
        if (bus.frame_tick && (bus.encounter || (DEBUG_KEYS && press_force))) begin
          state_d = ST_TRANS_IN;
          tc_d    = TC_LOAD;
        end else if (press_pause) begin
          state_d = ST_PAUSE;
        end
      end
      ST_TRANS_IN, ST_TRANS_OUT: if (bus.frame_tick) begin
        if (tc_q == '0) state_d = (state_q == ST_TRANS_IN) ? ST_BATTLE : ST_MAP;
        else            tc_d    = tc_q - 1'b1;
      end
      ST_BATTLE: if (bus.frame_tick) begin
        if (done_now) begin
          if (lost_now) state_d = ST_GAME_OVER;
          else begin
            state_d = ST_TRANS_OUT;
            tc_d    = TC_LOAD;
          end
        end else if (DEBUG_KEYS && press_start) begin
          state_d = ST_TRANS_OUT;
          tc_d    = TC_LOAD;
        end
      end
      ST_PAUSE: if (press_pause) state_d = ST_MAP;
      ST_GAME_OVER: if (press_start) begin
        state_d = ST_INIT;
        sel_d   = '0;
        valid_d = 1'b0;
      end
      default: state_d = ST_INIT;
    endcase

    // Flags only live while the battle continues; outside BATTLE done pulses are dropped.
    done_d = (state_q == ST_BATTLE) && (state_d == ST_BATTLE) && done_now;
    lost_d = (state_q == ST_BATTLE) && (state_d == ST_BATTLE) && lost_now;
  end

  always_comb begin
    bus.display_control = DISP_INIT;
    case (state_q)
      ST_INIT:                   bus.display_control = DISP_INIT;
      ST_SELECT:                 bus.display_control = DISP_SELECT;
      ST_MAP:                    bus.display_control = DISP_MAP;
      ST_BATTLE:                 bus.display_control = DISP_BATTLE;
      ST_TRANS_IN, ST_TRANS_OUT: bus.display_control = DISP_TRANS;
      ST_PAUSE:                  bus.display_control = DISP_PAUSE;
      ST_GAME_OVER:              bus.display_control = DISP_GAME_OVER;
      default:                   bus.display_control = DISP_INIT;
    endcase
  end

  assign bus.fight_on        = (state_q == ST_BATTLE);
  assign bus.during_battle   = (state_q == ST_BATTLE);
  assign bus.wild_poke_reg   = (state_q == ST_TRANS_IN) || (state_q == ST_BATTLE);
  assign bus.init_reg_select = !((state_q == ST_INIT) || (state_q == ST_SELECT) ||
                                 (state_q == ST_GAME_OVER));
  assign bus.trans_count     = tc_q;
  assign bus.starter_sel     = sel_q;
  assign bus.starter_valid   = valid_q;
  assign bus.state           = state_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl: main flow, fades, battle exits, pause, reset mid-fade,
// and a DEBUG_KEYS=0 instance sharing the same stimulus.
module tb_game_flow_ctrl;
  import game_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_pass = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  game_flow_ctrl_if #(.NUM_STARTERS(3), .TRANS_FRAMES(16)) bus ();
  game_flow_ctrl_if #(.NUM_STARTERS(3), .TRANS_FRAMES(16)) bus_nd ();

  assign bus_nd.frame_tick  = bus.frame_tick;
  assign bus_nd.keycode     = bus.keycode;
  assign bus_nd.encounter   = bus.encounter;
  assign bus_nd.battle_done = bus.battle_done;
  assign bus_nd.battle_lost = bus.battle_lost;

  game_flow_ctrl #(.DEBUG_KEYS(1'b1)) dut (
    .Clk    (clk),
    .Reset_n(rst_n),
    .bus    (bus.slave)
  );

  game_flow_ctrl #(.DEBUG_KEYS(1'b0)) dut_nd (
    .Clk    (clk),
    .Reset_n(rst_n),
    .bus    (bus_nd.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One frame tick: inputs driven at a falling edge, outputs sampled at the next falling edge.
  task automatic tick(input logic [7:0] k, input logic enc = 1'b0,
                      input logic done = 1'b0, input logic lost = 1'b0);
    @(negedge clk);
    bus.keycode     = k;
    bus.encounter   = enc;
    bus.battle_done = done;
    bus.battle_lost = lost;
    bus.frame_tick  = 1'b1;
    @(negedge clk);
    bus.frame_tick  = 1'b0;
    bus.encounter   = 1'b0;
    bus.battle_done = 1'b0;
    bus.battle_lost = 1'b0;
  endtask

  task automatic done_pulse(input logic lost);
    @(negedge clk);
    bus.battle_done = 1'b1;
    bus.battle_lost = lost;
    @(negedge clk);
    bus.battle_done = 1'b0;
    bus.battle_lost = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_disp"},  32'(bus.display_control), 32'd0);
    check({tag, "_state"}, 32'(bus.state), 32'(ST_INIT));
    check({tag, "_sel"},   32'(bus.starter_sel), 32'd0);
    check({tag, "_valid"}, 32'(bus.starter_valid), 32'd0);
    check({tag, "_tc"},    32'(bus.trans_count), 32'd0);
    check({tag, "_fight"}, 32'(bus.fight_on), 32'd0);
    check({tag, "_hud"},   32'(bus.during_battle), 32'd0);
    check({tag, "_wild"},  32'(bus.wild_poke_reg), 32'd0);
    check({tag, "_init"},  32'(bus.init_reg_select), 32'd0);
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.frame_tick  = 1'b0;
    bus.keycode     = 8'h00;
    bus.encounter   = 1'b0;
    bus.battle_done = 1'b0;
    bus.battle_lost = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Title -> select; holding start does nothing more.
    tick(8'h28);
    check("select_disp", 32'(bus.display_control), 32'd1);
    repeat (5) tick(8'h28);
    check("select_hold", 32'(bus.display_control), 32'd1);
    check("select_init", 32'(bus.init_reg_select), 32'd0);

    tick(8'h16);
    check("starter_sel", 32'(bus.starter_sel), 32'd1);
    check("starter_valid", 32'(bus.starter_valid), 32'd1);
    check("map_disp", 32'(bus.display_control), 32'd2);
    check("map_init", 32'(bus.init_reg_select), 32'd1);
    tick(8'h00);

    // Encounter fade: 16 ticks in total before battle.
    tick(8'h00, 1'b1);
    check("fade_in_disp", 32'(bus.display_control), 32'd4);
    check("fade_in_load", 32'(bus.trans_count), 32'd15);
    check("fade_in_wild", 32'(bus.wild_poke_reg), 32'd1);
    for (int i = 14; i >= 0; i--) begin
      tick(8'h00);
      check("fade_in_cnt", 32'(bus.trans_count), 32'(i));
    end
    check("fade_in_still", 32'(bus.state), 32'(ST_TRANS_IN));
    tick(8'h00);
    check("battle_disp", 32'(bus.display_control), 32'd3);
    check("battle_fight", 32'(bus.fight_on), 32'd1);
    check("battle_hud", 32'(bus.during_battle), 32'd1);
    check("battle_wild", 32'(bus.wild_poke_reg), 32'd1);
    check("battle_tc", 32'(bus.trans_count), 32'd0);

    // Win pulse between ticks is held until the next tick.
    done_pulse(1'b0);
    check("win_pending", 32'(bus.display_control), 32'd3);
    tick(8'h00);
    check("fade_out_state", 32'(bus.state), 32'(ST_TRANS_OUT));
    check("fade_out_load", 32'(bus.trans_count), 32'd15);
    check("fade_out_wild", 32'(bus.wild_poke_reg), 32'd0);
    check("fade_out_fight", 32'(bus.fight_on), 32'd0);
    repeat (15) tick(8'h00);
    check("fade_out_end_tc", 32'(bus.trans_count), 32'd0);
    check("fade_out_end_disp", 32'(bus.display_control), 32'd4);
    tick(8'h00);
    check("back_to_map", 32'(bus.display_control), 32'd2);
    check("back_map_valid", 32'(bus.starter_valid), 32'd1);

    // Pause toggle, with release in between.
    tick(8'h29);
    check("pause_disp", 32'(bus.display_control), 32'd5);
    tick(8'h29);
    check("pause_hold", 32'(bus.display_control), 32'd5);
    tick(8'h00);
    tick(8'h29);
    check("unpause", 32'(bus.display_control), 32'd2);
    tick(8'h00);

    // Encounter beats pause on the same tick.
    tick(8'h29, 1'b1);
    check("enc_vs_pause", 32'(bus.state), 32'(ST_TRANS_IN));
    repeat (16) tick(8'h00);
    check("battle2_disp", 32'(bus.display_control), 32'd3);

    // Loss pulse coinciding with a tick acts on that tick.
    tick(8'h00, 1'b0, 1'b1, 1'b1);
    check("game_over_disp", 32'(bus.display_control), 32'd6);
    check("game_over_init", 32'(bus.init_reg_select), 32'd0);
    check("game_over_fight", 32'(bus.fight_on), 32'd0);
    tick(8'h28);
    check("restart_disp", 32'(bus.display_control), 32'd0);
    check("restart_valid", 32'(bus.starter_valid), 32'd0);
    check("restart_sel", 32'(bus.starter_sel), 32'd0);

    // Reset in the middle of a fade, with start held through reset.
    tick(8'h00);
    tick(8'h28);
    tick(8'h04);
    check("starter0_sel", 32'(bus.starter_sel), 32'd0);
    check("starter0_disp", 32'(bus.display_control), 32'd2);
    tick(8'h00, 1'b1);
    repeat (8) tick(8'h00);
    check("mid_fade_tc", 32'(bus.trans_count), 32'd7);
    @(negedge clk);
    bus.keycode = 8'h28;
    rst_n       = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid_fade_reset");
    rst_n = 1'b1;
    tick(8'h28);
    check("held_through_reset", 32'(bus.display_control), 32'd1);
    tick(8'h28);
    check("held_once", 32'(bus.display_control), 32'd1);

    tick(8'h07);
    check("starter2_sel", 32'(bus.starter_sel), 32'd2);
    check("nd_map", 32'(bus_nd.display_control), 32'd2);

    // Done pulse outside battle must not leak into the next battle.
    done_pulse(1'b1);
    check("done_outside_map", 32'(bus.display_control), 32'd2);

    tick(8'h05);
    check("force_enc", 32'(bus.state), 32'(ST_TRANS_IN));
    check("nd_force_ignored", 32'(bus_nd.display_control), 32'd2);
    repeat (16) tick(8'h00);
    check("battle3_disp", 32'(bus.display_control), 32'd3);
    tick(8'h00);
    check("stale_done_ignored", 32'(bus.display_control), 32'd3);
    tick(8'h28);
    check("flee_state", 32'(bus.state), 32'(ST_TRANS_OUT));
    check("flee_tc", 32'(bus.trans_count), 32'd15);

    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end

endmodule

// File: doc/game_flow_ctrl.md
# game_flow_ctrl

Top-level game-flow controller: a parametrised successor to the original four-state game FSM. It sequences title, starter selection, overworld map, fade transitions, battle, pause and game-over screens. It drives the display-mode select and the register-load controls for the player and wild Pokémon datapaths. It runs on the system clock with a frame-rate enable, detects key edges so held keys act once, latches the chosen starter, and talks to the battle engine through explicit done/lost pulses.

## Interface
Parameters:
- NUM_STARTERS, 3: number of selectable starters (≥1).
- STARTER_KEYS, {8'h07,8'h16,8'h04}: packed NUM_STARTERS×8 keycodes; slice i selects starter i. Default maps 8'h04→0, 8'h16→1, 8'h07→2.
- KEY_START, 8'h28: start/confirm key.
- KEY_PAUSE, 8'h29: pause toggle key.
- KEY_FORCE, 8'h05: debug force-encounter key.
- DEBUG_KEYS, 1: enables KEY_FORCE in MAP and KEY_START flee in BATTLE.
- TRANS_FRAMES, 16: fade length in frames (≥1).

Ports:
- Clk, in, 1: system clock.
- Reset_n, in, 1: synchronous, active-low reset.
- frame_tick, in, 1: one-Clk strobe per video frame.
- keycode, in, 8: current USB keycode; 0 means no key.
- encounter, in, 1: random-encounter request, level-sensitive.
- battle_done, in, 1: one-Clk pulse from the battle engine when the battle ends.
- battle_lost, in, 1: qualifies battle_done; 1 means the player fainted.
- display_control, out, 3: screen mode.
- starter_sel, out, $clog2(NUM_STARTERS) (min 1): latched starter index.
- starter_valid, out, 1: starter_sel holds a chosen value.
- fight_on, out, 1: battle engine enable.
- during_battle, out, 1: HUD/HP bars active.
- wild_poke_reg, out, 1: wild-Pokémon register load enable.
- init_reg_select, out, 1: 0 = initialise player registers, 1 = keep existing values.
- trans_count, out, $clog2(TRANS_FRAMES+1): remaining fade frames, used by the colour mapper.

## Operation
- Key edge: key_prev is updated with keycode on every frame_tick. press(k) = frame_tick && keycode==k && keycode!=0 && keycode!=key_prev.
- States and display_control codes: INIT 0, SELECT 1, MAP 2, BATTLE 3, TRANS_IN 4, TRANS_OUT 4, PAUSE 5, GAME_OVER 6.
- INIT: press(KEY_START) moves to SELECT.
- SELECT: press(STARTER_KEYS[i]) latches starter_sel=i and sets starter_valid=1, then moves to MAP. If keys are duplicated, the lowest i wins.
- MAP, evaluated in priority order:
  - encounter at tick, or DEBUG_KEYS && press(KEY_FORCE): go to TRANS_IN and load trans_count with TRANS_FRAMES-1.
  - else press(KEY_PAUSE): go to PAUSE.
- TRANS_IN / TRANS_OUT: on each tick, if trans_count==0 go to BATTLE / MAP respectively; otherwise decrement. Each fade lasts exactly TRANS_FRAMES ticks.
- BATTLE:
  - done_flag is set on any Clk where battle_done=1. lost_flag is set when battle_done && battle_lost.
  - Both flags are cleared on exit from BATTLE.
  - At a tick, the done condition is (done_flag || battle_done). If lost → GAME_OVER. Else → TRANS_OUT, loading trans_count with TRANS_FRAMES-1.
  - DEBUG_KEYS && press(KEY_START) with no done condition → TRANS_OUT (flee).
- PAUSE: press(KEY_PAUSE) returns to MAP.
- GAME_OVER: press(KEY_START) goes to INIT and clears starter_valid and starter_sel.
- Outputs are Moore, decoded from state and registers:
  - fight_on = during_battle = BATTLE.
  - wild_poke_reg = TRANS_IN | BATTLE.
  - init_reg_select = 0 in INIT, SELECT and GAME_OVER; 1 otherwise.
- trans_count is 0 outside the fade states.

## Timing
- State, counter, key_prev and starter registers change only on Clk edges with frame_tick=1. Reset and the battle flags are the exceptions.
- Reset_n=0 at any Clk edge, including mid-fade or mid-battle, forces:
  - state INIT, display_control 0;
  - starter_sel 0, starter_valid 0;
  - key_prev 0, trans_count 0, both flags 0;
  - fight_on, during_battle and wild_poke_reg 0; init_reg_select 0.
- Outputs follow state in the same cycle the state register updates; latency from a qualifying tick to the new outputs is 1 Clk.
- A key held through reset registers as one press on the first tick after reset.
- A battle_done pulse between ticks is never lost. A pulse coinciding with a tick acts on that tick.
- battle_done outside BATTLE is ignored.
- encounter and KEY_PAUSE on the same tick in MAP: the encounter wins.

## Structure
- game_pkg: state enum (game_state_t), display_control code constants, and default keycode constants. Shared with the colour mapper.
- Sub-module key_edge_det (keycode, frame_tick → press, key_prev). It is reused by the battle menu.
- Everything else stays in one always_ff / always_comb pair.

## Test plan
- Reset, then a tick with keycode 8'h28 → SELECT, display_control=1. Hold 8'h28 for 5 more ticks → no further change.
- In SELECT, press 8'h16 → starter_sel=1, starter_valid=1, state MAP, init_reg_select=1.
- In MAP, raise encounter → TRANS_IN with trans_count 15..0 over 16 ticks, then BATTLE with fight_on=1 and wild_poke_reg=1.
- In BATTLE, pulse battle_done (lost=0) mid-frame → TRANS_OUT at the next tick, then MAP after 16 ticks. Pulse with lost=1 → GAME_OVER (display_control=6); 8'h28 → INIT with starter_valid=0.
- In MAP, press 8'h29 → PAUSE. Release, then press again → MAP. Press 8'h29 on the same tick as encounter → TRANS_IN.
- Drive Reset_n=0 at fade count 7 → all outputs at reset values on the next Clk. DEBUG_KEYS=0 build: 8'h05 in MAP has no effect.
